// File: rtl/rr_arb_mux.sv
// N-way stream mux with internal round-robin or fixed-priority arbitration.
// The output stage is a single register slice with a valid/ready handshake.
module rr_arb_mux #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned N          = 4,
  parameter int unsigned FIXED_PRIO = 0,
  localparam int unsigned SELW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  last_grant_q, last_grant_d;

  logic             can_accept_c;
  logic             found_c;
  logic [SELW-1:0]  grant_c;
  logic [WIDTH-1:0] grant_data_c;

  assign can_accept_c = !out_valid_q || out_ready;

  // Scan channels starting one past the last grant, wrapping modulo N.
  always_comb begin : arb
    int unsigned idx;
    grant_c = '0;
    found_c = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (FIXED_PRIO != 0) idx = k;
      else                 idx = (32'(last_grant_q) + 32'd1 + k) % N;
      for (int unsigned i = 0; i < N; i++) begin
        if (!found_c && (i == idx) && in_valid[i]) begin
          grant_c = SELW'(i);
          found_c = 1'b1;
        end
      end
    end
  end

  always_comb begin : data_mux
    grant_data_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (SELW'(i) == grant_c) grant_data_c = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin : ready_gen
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = can_accept_c && found_c && (grant_c == SELW'(i));
    end
  end

  // A granted request always transfers when the slice can accept.
  always_comb begin : next_state
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (can_accept_c) begin
      if (found_c) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data_c;
        out_sel_d   = grant_c;
        if (FIXED_PRIO == 0) last_grant_d = grant_c;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      last_grant_q <= SELW'(N - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: round-robin N=4, fixed-priority N=4 and round-robin N=3
// instances, each checked against a reference arbitration model at the falling edge.
module tb_rr_arb_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] vld  [3];
  logic [31:0] dat [3][4];
  logic       ordy [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input int n, input int fp, input int last, input logic [3:0] v);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (fp != 0) ? k : (last + 1 + k) % n;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int unsigned NG = (g == 2) ? 3 : 4;
    localparam int unsigned FP = (g == 1) ? 1 : 0;

    logic [NG-1:0]    iv, ir;
    logic [NG*32-1:0] idata;
    logic             ov, or_s;
    logic [31:0]      od;
    logic [1:0]       os;
    int               exp_last;
    bit               just_reset;
    logic [33:0]      sb[$];

    assign iv   = vld[g][NG-1:0];
    assign or_s = ordy[g];
    for (genvar c = 0; c < NG; c++) begin : dmap
      assign idata[c*32 +: 32] = dat[g][c];
    end

    rr_arb_mux #(.WIDTH(32), .N(NG), .FIXED_PRIO(FP)) dut (
      .clk(clk), .rst(rst),
      .in_valid(iv), .in_data(idata), .in_ready(ir),
      .out_valid(ov), .out_data(od), .out_sel(os), .out_ready(or_s)
    );

    // Compare the held beat, then model this cycle's drain and accept.
    always @(negedge clk) begin : mon
      int         ge;
      bit         can;
      logic [3:0] rexp;
      logic [33:0] front;
      string      pfx;
      pfx = $sformatf("u%0d", g);
      if (rst) begin
        sb.delete();
        exp_last   = NG - 1;
        just_reset = 1'b1;
      end else begin
        if (just_reset) begin
          check_val({pfx, ".rst_data"}, 64'(od), 64'd0);
          check_val({pfx, ".rst_sel"},  64'(os), 64'd0);
          just_reset = 1'b0;
        end
        check_val({pfx, ".out_valid"}, 64'(ov), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
          front = sb[0];
          check_val({pfx, ".out_sel"},  64'(os), 64'(front[33:32]));
          check_val({pfx, ".out_data"}, 64'(od), 64'(front[31:0]));
        end
        can  = (sb.size() == 0) || ordy[g];
        ge   = model_grant(NG, FP, exp_last, vld[g]);
        rexp = (can && ge >= 0) ? 4'(4'b0001 << ge) : 4'b0000;
        check_val({pfx, ".in_ready"}, 64'(ir), 64'(rexp));
        if (sb.size() != 0 && ordy[g]) void'(sb.pop_front());
        if (can && ge >= 0) begin
          sb.push_back({2'(ge), dat[g][ge]});
          if (FP == 0) exp_last = ge;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int g = 0; g < 3; g++) begin
      vld[g]  = 4'b0000;
      ordy[g] = 1'b1;
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++)
      for (int c = 0; c < 4; c++) dat[g][c] = 32'h0;
    idle_all();
    cyc(3);
    rst = 1'b0;

    // All four channels requesting: rotation 0,1,2,3,...
    for (int c = 0; c < 4; c++) dat[0][c] = 32'hA0 + 32'(c);
    vld[0] = 4'b1111;
    cyc(8);
    vld[0] = 4'b0000;
    cyc(2);

    // Single ch2 beat followed by a three-cycle stall with ch0/ch1 waiting.
    dat[0][2] = 32'h55;
    dat[0][0] = 32'h1000;
    dat[0][1] = 32'h1001;
    vld[0] = 4'b0100;
    cyc(1);
    vld[0]  = 4'b0011;
    ordy[0] = 1'b0;
    cyc(3);
    ordy[0] = 1'b1;
    cyc(2);
    vld[0] = 4'b0000;
    cyc(2);

    // Reset while a beat is stalled in the register.
    for (int c = 0; c < 4; c++) dat[0][c] = 32'hC0DE0000 + 32'(c);
    vld[0]  = 4'b1111;
    ordy[0] = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst     = 1'b0;
    ordy[0] = 1'b1;
    cyc(3);
    vld[0] = 4'b0000;
    cyc(2);

    // Fixed priority: channel 0 always wins.
    for (int c = 0; c < 4; c++) dat[1][c] = 32'hB0 + 32'(c);
    vld[1] = 4'b1111;
    cyc(4);
    ordy[1] = 1'b0;
    cyc(2);
    ordy[1] = 1'b1;
    cyc(2);
    vld[1] = 4'b0000;
    cyc(2);

    // Non-power-of-two rotation 0,1,2,0,...
    for (int c = 0; c < 3; c++) dat[2][c] = 32'hD0 + 32'(c);
    vld[2] = 4'b0111;
    cyc(7);
    vld[2] = 4'b0000;
    cyc(2);

    // Sparse traffic: idle, single ch3 pulse, idle.
    cyc(3);
    dat[0][3] = 32'hDEAD;
    vld[0] = 4'b1000;
    cyc(1);
    vld[0] = 4'b0000;
    cyc(3);

    // Random requests and backpressure on all instances.
    for (int t = 0; t < 400; t++) begin
      for (int g = 0; g < 3; g++) begin
        vld[g]  = 4'($urandom_range(0, 15));
        ordy[g] = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < 4; c++) dat[g][c] = $urandom;
      end
      cyc(1);
    end
    idle_all();
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-way, WIDTH-bit stream multiplexer with built-in arbitration and a registered, valid/ready-handshaked output.
- Successor to the combinational 4:1 select mux: the select is generated internally by round-robin or fixed-priority arbitration instead of an external sel.
- Sits in front of shared CPU resources such as the memory port or writeback bus, merging requests from several sources.
- Output carries the data plus the index of the granted source.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels; legal range 1..16, need not be a power of two.
- FIXED_PRIO, 0, arbitration mode. 0 = round-robin. 1 = fixed priority, where the lowest index wins.
- SELW (localparam), max(1, clog2(N)), width of the grant index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  N  per-channel request valid.
- in_data  input  N*WIDTH  flattened channel data; channel i is bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data of the granted channel.
- out_sel  output  SELW  registered index of the channel that supplied out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_sel=0, last_grant=N-1, so channel 0 has top priority after reset. Reset overrides any transfer in the same cycle; a beat held in the register is dropped.
- can_accept = !out_valid || out_ready, giving single-register pipelining at full throughput of 1 beat/cycle.
- Grant, combinational:
  - FIXED_PRIO=1: lowest i with in_valid[i]=1.
  - FIXED_PRIO=0: first i with in_valid[i]=1, scanning (last_grant+1) mod N upward and wrapping modulo N. Correct for non-power-of-two N; index N must never be produced.
- in_ready[i] = can_accept && any(in_valid) && (grant == i). All in_ready bits are 0 when no channel is valid.
- in_ready may depend on in_valid. in_valid must not depend on in_ready; this is a source requirement.
- Input transfer on channel g: in_valid[g] && in_ready[g]. On the next edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1, and last_grant <= g (round-robin mode only).
- No input transfer while can_accept: out_valid <= 0 if out_ready, otherwise the register is unchanged.
- Stall (out_valid && !out_ready): out_valid, out_data and out_sel are held stable. No in_ready is asserted and last_grant is unchanged.
- Latency: an input accepted at edge k appears on the outputs after edge k, i.e. in cycle k+1.
- Simultaneous output drain and input accept in the same cycle: the register reloads with no bubble.
- Fairness (round-robin): with all N channels continuously valid and out_ready=1, grants follow 0,1,...,N-1,0,... with no channel starved for more than N-1 beats.
- A channel dropping in_valid before being granted loses nothing; it is simply skipped.
- N=1: grant is always 0, out_sel is 0, and the block behaves as a one-stage register slice.
- No combinational path from in_data to out_data. The only combinational path to in_ready is from in_valid, out_valid and out_ready.

Test Plan:
1. N=4, WIDTH=32, round-robin. After reset, hold all in_valid=4'b1111 with in_data[i]=32'hA0+i and out_ready=1 for 8 cycles. Required: out_sel sequence 0,1,2,3,0,1,2,3; out_data 0xA0,0xA1,0xA2,0xA3,...; out_valid=1 from cycle 2 onward.
2. Backpressure. One beat from ch2 = 0x55 is accepted, then out_ready=0 for 3 cycles with ch0 and ch1 valid. Required: out_data=0x55 and out_sel=2 held stable; in_ready=0 throughout; when out_ready rises, ch0 wins next, since the scan starts from last_grant+1=3 and wraps to 0.
3. Reset mid-stall. Assert rst while out_valid=1 and out_ready=0. Required: next cycle out_valid=0, out_data=0, out_sel=0; first grant after release goes to channel 0 with all channels valid.
4. FIXED_PRIO=1, N=4, all channels valid for 4 cycles. Required: out_sel=0 every beat; in_ready=4'b0001 whenever can_accept.
5. N=3 (non-power-of-two), round-robin, all channels valid for 7 beats. Required: out_sel=0,1,2,0,1,2,0; out_sel never reaches 3.
6. Sparse traffic. in_valid=4'b0000, then a single pulse of 4'b1000 with data 0xDEAD. Required: no in_ready and out_valid=0 while idle; in_ready=4'b1000 in the pulse cycle; next cycle out_valid=1, out_data=0xDEAD, out_sel=3; with out_ready=1, out_valid returns to 0 the following cycle.
